// File: rtl/tcdm_rr_port_arbiter_if.sv
// Bundles the requester-side and TCDM-side signals of the round-robin port
// arbiter. The master modport is the arbiter's own view: it drives the
// shared TCDM port. The slave modport is the view of the surrounding logic.
interface tcdm_rr_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [N_REQ-1:0]                in_req;
  logic [N_REQ-1:0]                in_gnt;
  logic [N_REQ-1:0][AW-1:0]        in_add;
  logic [N_REQ-1:0]                in_wen;
  logic [N_REQ-1:0][DW/8-1:0]      in_be;
  logic [N_REQ-1:0][DW-1:0]        in_data;
  logic [DW-1:0]                   in_r_data;
  logic [N_REQ-1:0]                in_r_valid;

  logic                            tcdm_req;
  logic                            tcdm_gnt;
  logic [AW-1:0]                   tcdm_add;
  logic                            tcdm_wen;
  logic [DW/8-1:0]                 tcdm_be;
  logic [DW-1:0]                   tcdm_data;
  logic [DW-1:0]                   tcdm_r_data;
  logic                            tcdm_r_valid;

  modport master (
    input  in_req, in_add, in_wen, in_be, in_data,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    output in_gnt, in_r_data, in_r_valid,
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );

  modport slave (
    output in_req, in_add, in_wen, in_be, in_data,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid,
    input  in_gnt, in_r_data, in_r_valid,
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data
  );
endinterface

// File: rtl/tcdm_rr_port_arbiter.sv
// Round-robin sharing of one TCDM master port between N_REQ requester
// streams. Granted requester IDs are queued in order so each response is
// steered back to its issuer; a response with nothing outstanding sets a
// sticky error flag and is not forwarded.
module tcdm_rr_port_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_OUTST = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CW       = $clog2(MAX_OUTST + 1),
  localparam int PW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  tcdm_rr_port_arbiter_if.master bus,
  output logic [CW-1:0]          outst_o,
  output logic                   err_o
);

  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_OUTST);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(N_REQ - 1);
  localparam logic [PW-1:0]  LAST_PTR = PW'(MAX_OUTST - 1);

  logic [IDW-1:0] r_rr_ptr;
  logic [CW-1:0]  r_cnt;
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic           r_err;
  logic [IDW-1:0] r_fifo [MAX_OUTST];

  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_head;
  logic           w_open;
  logic           w_hs;
  logic           w_pop;

  // First requesting index at or after ptr, wrapping; ptr itself when idle
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [IDW-1:0]   ptr);
    logic [IDW-1:0] sel;
    int             idx;
    sel = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) sel = IDW'(idx);
    end
    return sel;
  endfunction

  // FIFO pointer increment with explicit wrap for non-power-of-2 depths
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_sel  = rr_pick(bus.in_req, r_rr_ptr);
  assign w_open = (r_cnt < MAX_CNT) && !rst_i;
  assign w_hs   = bus.tcdm_req && bus.tcdm_gnt;
  assign w_pop  = bus.tcdm_r_valid && (r_cnt != '0);
  assign w_head = r_fifo[r_rptr];

  assign bus.tcdm_req  = w_open && (|bus.in_req);
  assign bus.tcdm_add  = bus.in_add[w_sel];
  assign bus.tcdm_wen  = bus.in_wen[w_sel];
  assign bus.tcdm_be   = bus.in_be[w_sel];
  assign bus.tcdm_data = bus.in_data[w_sel];
  assign bus.in_r_data = bus.tcdm_r_data;

  assign outst_o = r_cnt;
  assign err_o   = r_err;

  // One-hot grant back to the selected requester on a TCDM handshake
  always_comb begin
    bus.in_gnt = '0;
    if (w_hs) bus.in_gnt[w_sel] = 1'b1;
  end

  // Steer a response to the requester at the head of the ID FIFO
  always_comb begin
    bus.in_r_valid = '0;
    if (w_pop) bus.in_r_valid[w_head] = 1'b1;
  end

  // Control state: round-robin pointer, FIFO pointers, occupancy, error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_wptr   <= ptr_inc(r_wptr);
        r_rr_ptr <= (w_sel == LAST_ID) ? '0 : w_sel + 1'b1;
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (bus.tcdm_r_valid && (r_cnt == '0)) r_err <= 1'b1;
    end
  end

  // ID storage; contents are only meaningful between write and read pointer
  always_ff @(posedge clk_i) begin
    if (w_hs) r_fifo[r_wptr] <= w_sel;
  end

endmodule

// File: tb/tb_tcdm_rr_port_arbiter.sv
// Bench for tcdm_rr_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_tcdm_rr_port_arbiter;
  localparam int N  = 4;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] outst;
  logic          err;

  tcdm_rr_port_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  tcdm_rr_port_arbiter #(.N_REQ(N), .MAX_OUTST(MO), .AW(AW), .DW(DW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .outst_o (outst),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  // bench-side stimulus state
  logic [N-1:0]  t_req;
  logic [N-1:0]  t_wen;
  logic [AW-1:0] t_add  [N];
  logic [BW-1:0] t_be   [N];
  logic [DW-1:0] t_data [N];
  logic          t_gnt;
  logic          t_rv;
  logic [DW-1:0] t_rdata;

  // reference model: priority index, queue of outstanding requester IDs, error
  int m_rr;
  int m_q[$];
  bit m_err;
  int last_gnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_sel();
    for (int k = 0; k < N; k++)
      if (t_req[(m_rr + k) % N]) return (m_rr + k) % N;
    return m_rr;
  endfunction

  function automatic bit m_req();
    return (m_q.size() < MO) && !rst && (t_req != '0);
  endfunction

  task automatic drive();
    bus.in_req       = t_req;
    bus.in_wen       = t_wen;
    for (int i = 0; i < N; i++) begin
      bus.in_add[i]  = t_add[i];
      bus.in_be[i]   = t_be[i];
      bus.in_data[i] = t_data[i];
    end
    bus.tcdm_gnt     = t_gnt;
    bus.tcdm_r_valid = t_rv;
    bus.tcdm_r_data  = t_rdata;
  endtask

  task automatic check_model();
    int           s;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;
    s     = m_sel();
    e_gnt = '0;
    e_rv  = '0;
    if (m_req() && t_gnt) e_gnt[s] = 1'b1;
    if (t_rv && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
    chk("tcdm_req",   64'(bus.tcdm_req),   64'(m_req()));
    chk("in_gnt",     64'(bus.in_gnt),     64'(e_gnt));
    chk("tcdm_add",   64'(bus.tcdm_add),   64'(t_add[s]));
    chk("tcdm_wen",   64'(bus.tcdm_wen),   64'(t_wen[s]));
    chk("tcdm_be",    64'(bus.tcdm_be),    64'(t_be[s]));
    chk("tcdm_data",  64'(bus.tcdm_data),  64'(t_data[s]));
    chk("in_r_valid", 64'(bus.in_r_valid), 64'(e_rv));
    chk("in_r_data",  64'(bus.in_r_data),  64'(t_rdata));
    chk("outst",      64'(outst),          64'(m_q.size()));
    chk("err",        64'(err),            64'(m_err));
  endtask

  task automatic model_update();
    int s;
    bit hs, pop, stray;
    s     = m_sel();
    hs    = m_req() && t_gnt;
    pop   = t_rv && (m_q.size() > 0);
    stray = t_rv && (m_q.size() == 0);
    if (rst) begin
      m_rr = 0;
      m_q.delete();
      m_err = 1'b0;
      last_gnt = -1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (hs) begin
        m_q.push_back(s);
        m_rr = (s + 1) % N;
      end
      if (stray) m_err = 1'b1;
      last_gnt = hs ? s : -1;
    end
  endtask

  task automatic cyc_begin();
    drive();
    #1;
    check_model();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set(input logic [N-1:0] req, input logic gnt, input logic rv);
    t_req = req;
    t_gnt = gnt;
    t_rv  = rv;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set('0, 1'b0, 1'b0);
    cyc_begin(); cyc_end();
    cyc_begin(); cyc_end();
    rst = 1'b0;
  endtask

  initial begin
    int eg[5];
    int erv[5];
    eg  = '{1, 2, 4, 8, 1};
    erv = '{0, 1, 2, 4, 8};
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      t_add[i]  = 32'h1000_0000 + 32'(i * 16);
      t_be[i]   = 4'(i + 1);
      t_data[i] = 32'hD000_0000 + 32'(i);
    end
    t_wen    = '1;
    t_rdata  = 32'h0;
    set('0, 1'b0, 1'b0);
    m_rr     = 0;
    m_err    = 1'b0;
    last_gnt = -1;
    drive();
    @(negedge clk);

    // all requesting, grant always high, response one cycle after each grant
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set(4'b1111, 1'b1, k > 0);
      t_rdata = 32'hAB00 + 32'(k);
      cyc_begin();
      chk("t1_gnt", 64'(bus.in_gnt), 64'(eg[k]));
      chk("t1_rv",  64'(bus.in_r_valid), 64'(erv[k]));
      cyc_end();
    end
    set('0, 1'b1, 1'b1);
    cyc_begin();
    chk("t1_rv_last", 64'(bus.in_r_valid), 64'd1);
    cyc_end();

    // outstanding limit blocks further requests until a response arrives
    do_reset();
    set(4'b1111, 1'b1, 1'b0);
    cyc_begin(); chk("t2_gnt0", 64'(bus.in_gnt), 64'd1); cyc_end();
    cyc_begin(); chk("t2_gnt1", 64'(bus.in_gnt), 64'd2); cyc_end();
    cyc_begin();
    chk("t2_req_full", 64'(bus.tcdm_req), 64'd0);
    chk("t2_outst",    64'(outst),        64'd2);
    cyc_end();
    set(4'b1111, 1'b1, 1'b1);
    cyc_begin();
    chk("t2_req_pop", 64'(bus.tcdm_req),   64'd0);
    chk("t2_rv",      64'(bus.in_r_valid), 64'd1);
    cyc_end();
    set(4'b1111, 1'b1, 1'b0);
    cyc_begin();
    chk("t2_req_again", 64'(bus.tcdm_req), 64'd1);
    chk("t2_gnt2",      64'(bus.in_gnt),   64'd4);
    cyc_end();
    set('0, 1'b0, 1'b1);
    cyc_begin(); chk("t2_drain0", 64'(bus.in_r_valid), 64'd2); cyc_end();
    cyc_begin(); chk("t2_drain1", 64'(bus.in_r_valid), 64'd4); cyc_end();

    // stalled grant holds selection and priority
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set(4'b0101, 1'b0, 1'b0);
      cyc_begin();
      chk("t3_req",   64'(bus.tcdm_req), 64'd1);
      chk("t3_add",   64'(bus.tcdm_add), 64'(t_add[0]));
      chk("t3_nognt", 64'(bus.in_gnt),   64'd0);
      cyc_end();
    end
    set(4'b0101, 1'b1, 1'b0);
    cyc_begin(); chk("t3_gnt0", 64'(bus.in_gnt), 64'd1); cyc_end();
    set(4'b0100, 1'b1, 1'b0);
    cyc_begin(); chk("t3_gnt2", 64'(bus.in_gnt), 64'd4); cyc_end();
    set('0, 1'b0, 1'b1);
    cyc_begin(); cyc_end();
    cyc_begin(); cyc_end();

    // write from 1 then read from 3; responses routed in order
    do_reset();
    t_wen[1] = 1'b0;
    t_wen[3] = 1'b1;
    set(4'b0010, 1'b1, 1'b0);
    cyc_begin();
    chk("t4_gnt1", 64'(bus.in_gnt),   64'd2);
    chk("t4_wen1", 64'(bus.tcdm_wen), 64'd0);
    cyc_end();
    set(4'b1000, 1'b1, 1'b1);
    t_rdata = 32'hCAFE_0001;
    cyc_begin();
    chk("t4_gnt3",  64'(bus.in_gnt),     64'd8);
    chk("t4_wen3",  64'(bus.tcdm_wen),   64'd1);
    chk("t4_rv1",   64'(bus.in_r_valid), 64'd2);
    chk("t4_rdat1", 64'(bus.in_r_data),  64'h0000_0000_CAFE_0001);
    cyc_end();
    set('0, 1'b0, 1'b1);
    t_rdata = 32'hBEEF_0002;
    cyc_begin();
    chk("t4_rv3",   64'(bus.in_r_valid), 64'd8);
    chk("t4_rdat3", 64'(bus.in_r_data),  64'h0000_0000_BEEF_0002);
    cyc_end();

    // stray response sets sticky error, cleared only by reset
    do_reset();
    set('0, 1'b0, 1'b1);
    cyc_begin();
    chk("t5_rv_none", 64'(bus.in_r_valid), 64'd0);
    chk("t5_err_pre", 64'(err),            64'd0);
    cyc_end();
    for (int k = 0; k < 3; k++) begin
      set('0, 1'b0, 1'b0);
      cyc_begin(); chk("t5_err_sticky", 64'(err), 64'd1); cyc_end();
    end
    do_reset();
    cyc_begin(); chk("t5_err_clr", 64'(err), 64'd0); cyc_end();

    // reset with two transactions outstanding
    do_reset();
    set(4'b1111, 1'b1, 1'b0);
    cyc_begin(); cyc_end();
    cyc_begin(); cyc_end();
    rst = 1'b1;
    cyc_begin();
    chk("t6_req_rst", 64'(bus.tcdm_req), 64'd0);
    chk("t6_gnt_rst", 64'(bus.in_gnt),   64'd0);
    chk("t6_outst2",  64'(outst),        64'd2);
    cyc_end();
    cyc_begin();
    chk("t6_outst0", 64'(outst), 64'd0);
    cyc_end();
    rst = 1'b0;
    cyc_begin();
    chk("t6_err0",   64'(err),        64'd0);
    chk("t6_gnt0",   64'(bus.in_gnt), 64'd1);
    cyc_end();
    set('0, 1'b0, 1'b1);
    cyc_begin(); cyc_end();

    // randomized traffic; requesters hold req/payload until granted
    t_req = '0;
    for (int c = 0; c < 3000; c++) begin
      if (last_gnt >= 0) t_req[last_gnt] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!t_req[i] && $urandom_range(3) == 0) begin
          t_req[i]  = 1'b1;
          t_add[i]  = $urandom;
          t_be[i]   = 4'($urandom);
          t_data[i] = $urandom;
          t_wen[i]  = 1'($urandom);
        end
      end
      t_gnt   = ($urandom_range(3) != 0);
      t_rv    = (m_q.size() > 0) ? 1'($urandom_range(1)) : ($urandom_range(40) == 0);
      t_rdata = $urandom;
      rst     = ($urandom_range(150) == 0);
      cyc_begin();
      cyc_end();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
